// File: rtl/tx_frame_if.sv
// Client-side transmit stream: one 64-bit frame word per accepted cycle.
interface tx_frame_if;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic [2:0]  tx_last_bytes;
  logic        tx_ready;

  modport master (
    output tx_data, tx_valid, tx_last, tx_last_bytes,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_valid, tx_last, tx_last_bytes,
    output tx_ready
  );
endinterface

// File: rtl/tx_frame_assemble.sv
// XGMII transmit framer: wraps client frame words with start/preamble/SFD,
// places the terminate character, flags underruns with /E/ and enforces a
// minimum inter-frame gap of idle words. /S/ is always placed in lane 0.
module tx_frame_assemble #(
  parameter int IFG_BYTES = 12
) (
  input  logic        txclk,
  input  logic        reset,
  tx_frame_if.slave   client,
  output logic [63:0] txd64,
  output logic [7:0]  txc8,
  output logic        tx_busy,
  output logic        tx_underrun,
  output logic        frame_done,
  output logic [15:0] frame_bytes
);

  localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
  localparam logic [63:0] START_WORD = 64'hFB555555555555AB;
  localparam logic [63:0] TERM_WORD  = 64'hFD07070707070707;
  localparam logic [63:0] ERR_WORD   = 64'hFEFEFEFEFEFEFEFE;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TERM, S_IFG} state_t;

  // Whole idle words still owed after a word that already carried k idle bytes.
  function automatic logic [1:0] extra_idles(input logic [2:0] k);
    logic [5:0] ifg;
    logic [5:0] need;
    ifg  = 6'(IFG_BYTES);
    need = (ifg > {3'b000, k}) ? (ifg - {3'b000, k}) : 6'd0;
    return 2'((need + 6'd7) >> 3);
  endfunction

  // Byte count addition that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t      state_q, state_d;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;
  logic        underrun_q, underrun_d;
  logic        done_q, done_d;
  logic [15:0] bytes_q, bytes_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [63:0] last_word;
  logic [1:0]  idles_last;
  logic [1:0]  idles_term;

  // Partial last word: data in lanes below n, /T/ in lane n, idles above.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      localparam logic [2:0] LANE = 3'(gi);
      assign last_word[63-8*gi -: 8] =
        (LANE < client.tx_last_bytes)  ? client.tx_data[63-8*gi -: 8] :
        (LANE == client.tx_last_bytes) ? 8'hFD : 8'h07;
    end
  endgenerate

  assign idles_last = extra_idles(3'd7 - client.tx_last_bytes);
  assign idles_term = extra_idles(3'd7);

  assign client.tx_ready = (state_q == S_DATA);
  assign tx_busy         = (state_q != S_IDLE);
  assign txd64           = txd_q;
  assign txc8            = txc_q;
  assign tx_underrun     = underrun_q;
  assign frame_done      = done_q;
  assign frame_bytes     = bytes_q;

  // State and registered XGMII/status outputs.
  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      txd_q      <= IDLE_WORD;
      txc_q      <= 8'hFF;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
      bytes_q    <= 16'h0000;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      txc_q      <= txc_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
      bytes_q    <= bytes_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next state and next output word; idle word is the default output.
  always_comb begin
    state_d    = state_q;
    txd_d      = IDLE_WORD;
    txc_d      = 8'hFF;
    underrun_d = 1'b0;
    done_d     = 1'b0;
    bytes_d    = bytes_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (client.tx_valid) begin
          txd_d   = START_WORD;
          txc_d   = 8'h80;
          bytes_d = 16'h0000;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!client.tx_valid) begin
          txd_d      = ERR_WORD;
          underrun_d = 1'b1;
          state_d    = S_TERM;
        end else if (!client.tx_last || client.tx_last_bytes == 3'd0) begin
          txd_d   = client.tx_data;
          txc_d   = 8'h00;
          bytes_d = sat_add(bytes_q, 4'd8);
          if (client.tx_last) begin
            done_d  = 1'b1;
            state_d = S_TERM;
          end
        end else begin
          // Control bits set for lane n (the /T/) and every lane after it.
          txd_d   = last_word;
          txc_d   = 8'hFF >> client.tx_last_bytes;
          bytes_d = sat_add(bytes_q, {1'b0, client.tx_last_bytes});
          done_d  = 1'b1;
          cnt_d   = idles_last;
          state_d = (idles_last == 2'd0) ? S_IDLE : S_IFG;
        end
      end
      S_TERM: begin
        txd_d   = TERM_WORD;
        cnt_d   = idles_term;
        state_d = (idles_term == 2'd0) ? S_IDLE : S_IFG;
      end
      S_IFG: begin
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_frame_assemble.sv
// Directed bench for the XGMII transmit framer (default gap and zero gap).
module tb_tx_frame_assemble;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hFB555555555555AB;
  localparam logic [63:0] TERM_W  = 64'hFD07070707070707;
  localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;

  logic        txclk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] txd64, txd64_z;
  logic [7:0]  txc8, txc8_z;
  logic        tx_busy, tx_underrun, frame_done;
  logic        tx_busy_z, tx_underrun_z, frame_done_z;
  logic [15:0] frame_bytes, frame_bytes_z;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  tx_frame_if c ();
  tx_frame_if c0 ();

  always #5 txclk = ~txclk;

  tx_frame_assemble #(.IFG_BYTES(12)) dut (
    .txclk(txclk), .reset(reset), .client(c),
    .txd64(txd64), .txc8(txc8), .tx_busy(tx_busy),
    .tx_underrun(tx_underrun), .frame_done(frame_done), .frame_bytes(frame_bytes)
  );

  tx_frame_assemble #(.IFG_BYTES(0)) dut0 (
    .txclk(txclk), .reset(reset), .client(c0),
    .txd64(txd64_z), .txc8(txc8_z), .tx_busy(tx_busy_z),
    .tx_underrun(tx_underrun_z), .frame_done(frame_done_z), .frame_bytes(frame_bytes_z)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge txclk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] pat(input int i);
    return {16'(i), 48'h0123_4567_89AB};
  endfunction

  // Drives one frame on dut (tx_valid must already be high or is raised
  // here) and checks every output word through the end of the gap.
  task automatic run_frame(input string tag, input int nwords, input logic [2:0] lb,
                           input logic [63:0] last_data, input logic [63:0] exp_last,
                           input logic [7:0] exp_last_c, input int exp_idles,
                           input logic [15:0] exp_bytes, input bit hold);
    logic [63:0] w;
    c.tx_valid = 1'b1;
    c.tx_data = pat(0);
    c.tx_last = (nwords == 1);
    c.tx_last_bytes = lb;
    tick();
    check({tag, " start txd"}, txd64, START_W);
    check({tag, " start txc"}, {56'b0, txc8}, 64'h80);
    check({tag, " start bytes"}, {48'b0, frame_bytes}, 64'h0);
    check({tag, " ready"}, {63'b0, c.tx_ready}, 64'h1);
    for (int i = 0; i < nwords; i++) begin
      w = (i == nwords - 1) ? last_data : pat(i);
      c.tx_data = w;
      c.tx_last = (i == nwords - 1);
      tick();
      if (i < nwords - 1) begin
        if (txd64 !== w || txc8 !== 8'h00 || frame_done !== 1'b0)
          check({tag, " data word"}, {txd64[63:9], frame_done, txc8}, {w[63:9], 1'b0, 8'h00});
      end else begin
        check({tag, " last txd"}, txd64, exp_last);
        check({tag, " last txc"}, {56'b0, txc8}, {56'b0, exp_last_c});
        check({tag, " done"}, {63'b0, frame_done}, 64'h1);
        check({tag, " bytes"}, {48'b0, frame_bytes}, {48'b0, exp_bytes});
      end
    end
    c.tx_valid = hold;
    c.tx_last = 1'b0;
    c.tx_data = pat(99);
    if (lb == 3'd0) begin
      tick();
      check({tag, " term txd"}, txd64, TERM_W);
      check({tag, " term txc"}, {56'b0, txc8}, 64'hFF);
      check({tag, " term done"}, {63'b0, frame_done}, 64'h0);
    end
    for (int j = 0; j < exp_idles; j++) begin
      tick();
      check({tag, " ifg txd"}, txd64, IDLE_W);
      check({tag, " ifg txc/ready"}, {55'b0, c.tx_ready, txc8}, 64'h0FF);
    end
    check({tag, " busy after gap"}, {63'b0, tx_busy}, 64'h0);
    $display("[TB] frame %s: %0d words, %0d idle words, %0d bytes", tag, nwords, exp_idles, exp_bytes);
  endtask

  initial begin
    int start;
    c.tx_valid = 1'b0; c.tx_last = 1'b0; c.tx_last_bytes = 3'd0; c.tx_data = '0;
    c0.tx_valid = 1'b0; c0.tx_last = 1'b0; c0.tx_last_bytes = 3'd0; c0.tx_data = '0;
    reset = 1'b1;
    tick(); tick();
    check("reset txd", txd64, IDLE_W);
    check("reset txc", {56'b0, txc8}, 64'hFF);
    check("reset flags", {59'b0, c.tx_ready, tx_busy, tx_underrun, frame_done, 1'b0}, 64'h0);
    check("reset bytes", {48'b0, frame_bytes}, 64'h0);
    reset = 1'b0;
    tick();
    $display("[TB] reset released");

    // 64-byte frame: 11 cycles from tx_valid to IDLE.
    start = cyc;
    run_frame("f64", 8, 3'd0, pat(7), pat(7), 8'h00, 1, 16'd64, 1'b0);
    check("f64 cycles", 64'(cyc - start), 64'd11);

    run_frame("n4", 2, 3'd4, 64'h1122334455667788, 64'h11223344FD070707, 8'h0F, 2, 16'd12, 1'b0);
    run_frame("n7", 1, 3'd7, 64'hAABBCCDDEEFF1122, 64'hAABBCCDDEEFF11FD, 8'h01, 2, 16'd7, 1'b0);
    run_frame("n1", 3, 3'd1, 64'h99AABBCCDDEEFF00, 64'h99FD070707070707, 8'h7F, 1, 16'd17, 1'b0);

    // Back-to-back with tx_valid held high throughout the gaps.
    run_frame("b2b_a", 2, 3'd4, 64'h1122334455667788, 64'h11223344FD070707, 8'h0F, 2, 16'd12, 1'b1);
    run_frame("b2b_b", 2, 3'd0, pat(1), pat(1), 8'h00, 1, 16'd16, 1'b1);
    run_frame("b2b_c", 1, 3'd2, 64'hCAFE000000000000, 64'hCAFEFD0707070707, 8'h3F, 1, 16'd2, 1'b0);

    // Underrun after 3 accepted words.
    c.tx_valid = 1'b1; c.tx_last = 1'b0; c.tx_data = pat(0);
    tick();
    check("ur start", txd64, START_W);
    for (int i = 0; i < 3; i++) begin
      c.tx_data = pat(i);
      tick();
      check("ur data", {txd64[63:1], frame_done}, {pat(i)[63:1], 1'b0});
    end
    c.tx_valid = 1'b0;
    tick();
    check("ur err txd", txd64, ERR_W);
    check("ur err txc", {56'b0, txc8}, 64'hFF);
    check("ur pulse/done", {62'b0, tx_underrun, frame_done}, 64'h2);
    check("ur bytes", {48'b0, frame_bytes}, 64'd24);
    tick();
    check("ur term", {txd64, 7'b0, tx_underrun}, {TERM_W, 8'h00});
    check("ur term done", {63'b0, frame_done}, 64'h0);
    tick();
    check("ur ifg", {txd64, 7'b0, tx_busy}, {IDLE_W, 8'h00});
    $display("[TB] frame underrun: 3 words then /E/");

    // Reset in the middle of DATA, then a clean restart.
    c.tx_valid = 1'b1; c.tx_data = pat(0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check("mid reset txd", txd64, IDLE_W);
    check("mid reset txc", {56'b0, txc8}, 64'hFF);
    check("mid reset flags", {62'b0, c.tx_ready, tx_busy}, 64'h0);
    check("mid reset bytes", {48'b0, frame_bytes}, 64'h0);
    reset = 1'b0;
    run_frame("after_reset", 2, 3'd0, pat(1), pat(1), 8'h00, 1, 16'd16, 1'b0);

    // Byte counter saturates: 8192 full words would be 65536 bytes.
    run_frame("sat", 8192, 3'd0, pat(8191), pat(8191), 8'h00, 1, 16'hFFFF, 1'b0);

    // Zero-gap instance: the next /S/ follows the terminating word directly.
    c0.tx_valid = 1'b1; c0.tx_last = 1'b1; c0.tx_last_bytes = 3'd7;
    c0.tx_data = 64'h0102030405060708;
    tick();
    check("z start", txd64_z, START_W);
    tick();
    check("z last txd", txd64_z, 64'h01020304050607FD);
    check("z last txc/done", {55'b0, frame_done_z, txc8_z}, 64'h101);
    check("z idle now", {63'b0, tx_busy_z}, 64'h0);
    tick();
    check("z next start", txd64_z, START_W);
    check("z next txc", {56'b0, txc8_z}, 64'h80);
    c0.tx_valid = 1'b0;
    tick();
    $display("[TB] frame zero_gap: back-to-back /S/");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
